// File: rtl/bitstream_queue.sv
// Bit-granular FIFO: accepts 0..IN_WIDTH bits and releases 0..OUT_WIDTH bits per cycle over valid/ready.
// Optional macro BITQ_FLUSH_EN adds a synchronous flush input that empties the queue.
module bitstream_queue #(
  parameter int IN_WIDTH  = 64,
  parameter int OUT_WIDTH = 64,
  parameter int DEPTH     = 256
) (
  input  logic                           clk,
  input  logic                           reset,
`ifdef BITQ_FLUSH_EN
  input  logic                           flush,
`endif
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [$clog2(IN_WIDTH+1)-1:0]  in_cnt,
  input  logic [0:IN_WIDTH-1]            in_data,
  input  logic [$clog2(OUT_WIDTH+1)-1:0] out_cnt,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [0:OUT_WIDTH-1]           out_data,
  output logic [$clog2(DEPTH+1)-1:0]     used_cnt,
  output logic [$clog2(DEPTH+1)-1:0]     free_cnt
);

  localparam int ICW = $clog2(IN_WIDTH+1);
  localparam int OCW = $clog2(OUT_WIDTH+1);
  localparam int UW  = $clog2(DEPTH+1);
  localparam int PW  = $clog2(DEPTH);
  localparam int XW  = $clog2(DEPTH+OUT_WIDTH);

  localparam logic [PW:0]    DEPTH_X  = (PW+1)'(DEPTH);
  localparam logic [UW-1:0]  DEPTH_U  = UW'(DEPTH);
  localparam logic [UW-1:0]  IN_LIMIT = UW'(DEPTH - IN_WIDTH);
  localparam logic [ICW-1:0] IN_MAX   = ICW'(IN_WIDTH);
  localparam logic [OCW-1:0] OUT_MAX  = OCW'(OUT_WIDTH);

  if (DEPTH < IN_WIDTH + OUT_WIDTH) begin : g_depth_check
    $error("bitstream_queue: DEPTH must be >= IN_WIDTH + OUT_WIDTH");
  end

  // Handshake rule for both ports: a transfer happens at a rising clk edge exactly when
  // valid && ready; in_ready depends only on stored count, out_valid on count and out_cnt.
  logic [DEPTH-1:0]           store;
  logic [DEPTH+OUT_WIDTH-1:0] ext;
  logic [PW-1:0]              head;
  logic [PW-1:0]              tail;
  logic [UW-1:0]              count;
  logic                       flush_i;
  logic                       enq;
  logic                       deq;

`ifdef BITQ_FLUSH_EN
  assign flush_i = flush;
`else
  assign flush_i = 1'b0;
`endif

  // Wrapping pointer add without a modulo: sum is at most 2*DEPTH-2, so one subtract suffices.
  function automatic logic [PW-1:0] ptr_add(input logic [PW-1:0] base, input logic [PW:0] off);
    logic [PW:0] sum;
    sum = {1'b0, base} + off;
    if (sum >= DEPTH_X) sum = sum - DEPTH_X;
    return sum[PW-1:0];
  endfunction

  assign in_ready  = (count <= IN_LIMIT);
  assign out_valid = (out_cnt != '0) && (UW'(out_cnt) <= count);
  assign enq       = in_valid && in_ready && !flush_i;
  assign deq       = out_valid && out_ready && !flush_i;
  assign used_cnt  = count;
  assign free_cnt  = DEPTH_U - count;

  always_ff @(posedge clk) begin
    if (reset || flush_i) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (enq) tail <= ptr_add(tail, (PW+1)'(in_cnt));
      if (deq) head <= ptr_add(head, (PW+1)'(out_cnt));
      count <= count + (enq ? UW'(in_cnt) : '0) - (deq ? UW'(out_cnt) : '0);
    end
  end

  // Storage is deliberately not reset; only bits below in_cnt are written.
  always_ff @(posedge clk) begin
    if (enq && !reset) begin
      for (int i = 0; i < IN_WIDTH; i++) begin
        if (i < int'(in_cnt)) store[ptr_add(tail, (PW+1)'(i))] <= in_data[i];
      end
    end
  end

  // Extended view repeats the first OUT_WIDTH bits past the end so the head window never wraps.
  assign ext = {store[OUT_WIDTH-1:0], store};

  always_comb begin
    out_data = '0;
    for (int i = 0; i < OUT_WIDTH; i++) begin
      out_data[i] = ext[XW'(head) + XW'(i)];
    end
  end

  assert property (@(posedge clk) disable iff (reset) in_cnt <= IN_MAX)
    else $fatal(1, "bitstream_queue: in_cnt exceeds IN_WIDTH");
  assert property (@(posedge clk) disable iff (reset) out_cnt <= OUT_MAX)
    else $fatal(1, "bitstream_queue: out_cnt exceeds OUT_WIDTH");

endmodule
